// File: rtl/carfield_mbox_pkg.sv
// Shared definitions for the Carfield security-island mailbox.
// Register map offsets, STATUS/IRQ_EN field positions and level type.
package carfield_mbox_pkg;

  typedef enum logic [3:0] {
    MboxTxData = 4'h0,
    MboxRxData = 4'h1,
    MboxStatus = 4'h2,
    MboxIrqEn  = 4'h3,
    MboxFlush  = 4'h4
  } mbox_reg_e;

  localparam int unsigned MboxDepth = 8;

  localparam int StatusRxLvlLsb   = 0;
  localparam int StatusTxLvlLsb   = 8;
  localparam int StatusLvlW       = 4;
  localparam int StatusRxEmptyBit = 16;
  localparam int StatusTxFullBit  = 17;

  localparam int IrqEnRxNeBit   = 0;
  localparam int IrqEnThreshBit = 1;
  localparam int IrqThreshLsb   = 8;
  localparam int IrqThreshW     = 4;

  localparam logic [31:0] IrqEnMask = 32'h0000_0F03;

  typedef logic [$clog2(MboxDepth):0] mbox_level_t;

endpackage

// File: rtl/carfield_mbox_fifo.sv
// Single-direction mailbox FIFO with flush and occupancy level.
// Flush has priority over any push or pop in the same cycle.
module carfield_mbox_fifo
  import carfield_mbox_pkg::*;
#(
  parameter int unsigned Depth     = MboxDepth,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LvlW      = $clog2(Depth) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 pop,
  input  logic                 flush,
  output logic [DataWidth-1:0] head,
  output logic                 full,
  output logic                 empty,
  output logic [LvlW-1:0]      level
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      rdPtr;
  logic                 doPush;
  logic                 doPop;

  assign full   = (level == LvlW'(Depth));
  assign empty  = (level == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (doPop) rdPtr <= rdPtr + PtrW'(1);
      level <= level + LvlW'(doPush) - LvlW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end

endmodule

// File: rtl/carfield_mbox_apb.sv
// Two-sided APB4 mailbox: side A is the host, side B the security island.
// Each side owns one outgoing FIFO and reads the peer's FIFO.
module carfield_mbox_apb
  import carfield_mbox_pkg::*;
#(
  parameter int unsigned Depth     = MboxDepth,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] a_paddr_i,
  input  logic                 a_psel_i,
  input  logic                 a_penable_i,
  input  logic                 a_pwrite_i,
  input  logic [DataWidth-1:0] a_pwdata_i,
  input  logic [3:0]           a_pstrb_i,
  output logic [DataWidth-1:0] a_prdata_o,
  output logic                 a_pready_o,
  output logic                 a_pslverr_o,
  input  logic [AddrWidth-1:0] b_paddr_i,
  input  logic                 b_psel_i,
  input  logic                 b_penable_i,
  input  logic                 b_pwrite_i,
  input  logic [DataWidth-1:0] b_pwdata_i,
  input  logic [3:0]           b_pstrb_i,
  output logic [DataWidth-1:0] b_prdata_o,
  output logic                 b_pready_o,
  output logic                 b_pslverr_o,
  output logic                 irq_a_o,
  output logic                 irq_b_o
);

  localparam int unsigned LvlW = $clog2(Depth) + 1;

  logic [AddrWidth-1:0] paddr   [2];
  logic                 psel    [2];
  logic                 penable [2];
  logic                 pwrite  [2];
  logic [DataWidth-1:0] pwdata  [2];
  logic [3:0]           pstrb   [2];
  logic [DataWidth-1:0] prdata  [2];
  logic                 pready  [2];
  logic                 pslverr [2];
  logic                 irq     [2];

  assign paddr[0]   = a_paddr_i;
  assign paddr[1]   = b_paddr_i;
  assign psel[0]    = a_psel_i;
  assign psel[1]    = b_psel_i;
  assign penable[0] = a_penable_i;
  assign penable[1] = b_penable_i;
  assign pwrite[0]  = a_pwrite_i;
  assign pwrite[1]  = b_pwrite_i;
  assign pwdata[0]  = a_pwdata_i;
  assign pwdata[1]  = b_pwdata_i;
  assign pstrb[0]   = a_pstrb_i;
  assign pstrb[1]   = b_pstrb_i;

  assign a_prdata_o  = prdata[0];
  assign b_prdata_o  = prdata[1];
  assign a_pready_o  = pready[0];
  assign b_pready_o  = pready[1];
  assign a_pslverr_o = pslverr[0];
  assign b_pslverr_o = pslverr[1];
  assign irq_a_o     = irq[0];
  assign irq_b_o     = irq[1];

  logic unusedAddrBits;
  assign unusedAddrBits = ^{paddr[0][1:0], paddr[1][1:0]};

  // FIFO f carries words written by side f toward side 1-f.
  logic [DataWidth-1:0] head  [2];
  logic                 full  [2];
  logic                 empty [2];
  logic [LvlW-1:0]      level [2];
  logic                 sidePush  [2];
  logic                 sidePop   [2];
  logic                 sideFlush [2];

  for (genvar f = 0; f < 2; f++) begin : gFifo
    carfield_mbox_fifo #(
      .Depth     (Depth),
      .DataWidth (DataWidth),
      .LvlW      (LvlW)
    ) uFifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (sidePush[f]),
      .wdata (pwdata[f]),
      .pop   (sidePop[1-f]),
      .flush (sideFlush[f]),
      .head  (head[f]),
      .full  (full[f]),
      .empty (empty[f]),
      .level (level[f])
    );
  end

  for (genvar s = 0; s < 2; s++) begin : gSide
    localparam int Tx = s;
    localparam int Rx = 1 - s;

    logic                 acc;
    logic                 respQ;
    logic                 errQ;
    logic                 irqQ;
    logic [DataWidth-1:0] rdataQ;
    logic [DataWidth-1:0] enQ;
    logic [DataWidth-1:0] status;
    logic [DataWidth-1:0] opData;
    logic [3:0]           off;
    logic                 hiBad;
    logic                 opErr;
    logic                 opPush;
    logic                 opPop;
    logic                 opFlush;
    logic                 opEn;
    logic                 irqNext;

    // The operation happens in IDLE; RESP only presents the result.
    assign acc   = ~respQ & psel[s] & penable[s];
    assign off   = paddr[s][5:2];
    assign hiBad = |paddr[s][AddrWidth-1:6];

    always_comb begin
      status = '0;
      status[StatusRxLvlLsb +: StatusLvlW] = StatusLvlW'(level[Rx]);
      status[StatusTxLvlLsb +: StatusLvlW] = StatusLvlW'(level[Tx]);
      status[StatusRxEmptyBit] = empty[Rx];
      status[StatusTxFullBit]  = full[Tx];
    end

    always_comb begin
      opData  = '0;
      opErr   = 1'b0;
      opPush  = 1'b0;
      opPop   = 1'b0;
      opFlush = 1'b0;
      opEn    = 1'b0;
      if (hiBad) begin
        opErr = 1'b1;
      end else begin
        unique case (1'b1)
          (off == MboxTxData): begin
            if (pwrite[s]) begin
              if (pstrb[s] != 4'hF || full[Tx]) opErr = 1'b1;
              else opPush = 1'b1;
            end
          end
          (off == MboxRxData): begin
            if (pwrite[s] || empty[Rx]) begin
              opErr = 1'b1;
            end else begin
              opPop  = 1'b1;
              opData = head[Rx];
            end
          end
          (off == MboxStatus): begin
            if (!pwrite[s]) opData = status;
          end
          (off == MboxIrqEn): begin
            if (pwrite[s]) opEn = 1'b1;
            else opData = enQ;
          end
          (off == MboxFlush): begin
            if (pwrite[s]) opFlush = pwdata[s][0];
          end
          default: opErr = 1'b1;
        endcase
      end
    end

    assign sidePush[s]  = acc & opPush;
    assign sidePop[s]   = acc & opPop;
    assign sideFlush[s] = acc & opFlush;

    assign irqNext =
      (enQ[IrqEnRxNeBit] & ~empty[Rx]) |
      (enQ[IrqEnThreshBit] &
       (32'(level[Rx]) >= 32'(enQ[IrqThreshLsb +: IrqThreshW])));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        respQ  <= 1'b0;
        errQ   <= 1'b0;
        rdataQ <= '0;
        enQ    <= '0;
        irqQ   <= 1'b0;
      end else begin
        respQ <= acc;
        if (acc) begin
          rdataQ <= opData;
          errQ   <= opErr;
        end
        if (acc & opEn) enQ <= pwdata[s] & IrqEnMask;
        irqQ <= irqNext;
      end
    end

    assign pready[s]  = respQ;
    assign prdata[s]  = respQ ? rdataQ : '0;
    assign pslverr[s] = respQ & errQ;
    assign irq[s]     = irqQ;
  end

endmodule

// File: tb/tb_carfield_mbox_apb.sv
// Self-checking bench for carfield_mbox_apb: directed scenarios plus
// randomized traffic compared against a queue-based mailbox model.
module tb_carfield_mbox_apb;

  localparam int Depth = 8;
  localparam logic [11:0] ATx = 12'h000;
  localparam logic [11:0] ARx = 12'h004;
  localparam logic [11:0] ASt = 12'h008;
  localparam logic [11:0] AEn = 12'h00C;
  localparam logic [11:0] AFl = 12'h010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] paddr   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic        irq     [2];

  int checks = 0;
  int errors = 0;

  carfield_mbox_apb dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .a_paddr_i   (paddr[0]),
    .a_psel_i    (psel[0]),
    .a_penable_i (penable[0]),
    .a_pwrite_i  (pwrite[0]),
    .a_pwdata_i  (pwdata[0]),
    .a_pstrb_i   (pstrb[0]),
    .a_prdata_o  (prdata[0]),
    .a_pready_o  (pready[0]),
    .a_pslverr_o (pslverr[0]),
    .b_paddr_i   (paddr[1]),
    .b_psel_i    (psel[1]),
    .b_penable_i (penable[1]),
    .b_pwrite_i  (pwrite[1]),
    .b_pwdata_i  (pwdata[1]),
    .b_pstrb_i   (pstrb[1]),
    .b_prdata_o  (prdata[1]),
    .b_pready_o  (pready[1]),
    .b_pslverr_o (pslverr[1]),
    .irq_a_o     (irq[0]),
    .irq_b_o     (irq[1])
  );

  // request staging and captured responses
  bit          rqAct  [2];
  bit          rqWr   [2];
  logic [11:0] rqAddr [2];
  logic [31:0] rqData [2];
  logic [3:0]  rqStrb [2];
  logic [31:0] rsData [2];
  logic        rsErr  [2];
  logic        rsIrq  [2];
  int          rsWaits;

  // reference model: one queue per direction plus enable registers
  logic [31:0] qAB [$];
  logic [31:0] qBA [$];
  logic [31:0] mEn [2];
  logic [31:0] mExpData [2];
  bit          mExpErr  [2];
  bit          ePush [2];
  bit          ePop  [2];
  bit          eFlush[2];
  bit          eEn   [2];

  function automatic int qSize(input int f);
    return (f == 0) ? qAB.size() : qBA.size();
  endfunction

  function automatic logic [31:0] qHead(input int f);
    return (f == 0) ? qAB[0] : qBA[0];
  endfunction

  function automatic bit modelIrq(input int s);
    int lvl;
    int th;
    lvl = qSize(1 - s);
    th  = int'(mEn[s][11:8]);
    return (mEn[s][0] && lvl != 0) || (mEn[s][1] && lvl >= th);
  endfunction

  task automatic modelEval(input int s);
    int txs;
    int rxs;
    int off;
    txs = qSize(s);
    rxs = qSize(1 - s);
    off = int'(rqAddr[s][5:2]);
    mExpData[s] = 32'h0;
    mExpErr[s]  = 1'b0;
    ePush[s] = 0; ePop[s] = 0; eFlush[s] = 0; eEn[s] = 0;
    if (rqAddr[s][11:6] != 6'd0) begin
      mExpErr[s] = 1'b1;
    end else if (off == 0) begin
      if (rqWr[s]) begin
        if (rqStrb[s] != 4'hF || txs == Depth) mExpErr[s] = 1'b1;
        else ePush[s] = 1;
      end
    end else if (off == 1) begin
      if (rqWr[s] || rxs == 0) mExpErr[s] = 1'b1;
      else begin
        ePop[s] = 1;
        mExpData[s] = qHead(1 - s);
      end
    end else if (off == 2) begin
      if (!rqWr[s])
        mExpData[s] = 32'(rxs) | (32'(txs) << 8) |
                      (32'(rxs == 0) << 16) | (32'(txs == Depth) << 17);
    end else if (off == 3) begin
      if (rqWr[s]) eEn[s] = 1;
      else mExpData[s] = mEn[s];
    end else if (off == 4) begin
      if (rqWr[s]) eFlush[s] = rqData[s][0];
    end else begin
      mExpErr[s] = 1'b1;
    end
  endtask

  task automatic modelCommit();
    if (ePop[1]) void'(qAB.pop_front());
    if (ePop[0]) void'(qBA.pop_front());
    if (ePush[0]) qAB.push_back(rqData[0]);
    if (ePush[1]) qBA.push_back(rqData[1]);
    if (eFlush[0]) qAB.delete();
    if (eFlush[1]) qBA.delete();
    for (int s = 0; s < 2; s++)
      if (eEn[s]) mEn[s] = rqData[s] & 32'h0000_0F03;
  endtask

  task automatic runXfer();
    bit done;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      if (rqAct[s]) begin
        psel[s]    = 1'b1;
        penable[s] = 1'b0;
        pwrite[s]  = rqWr[s];
        paddr[s]   = rqAddr[s];
        pwdata[s]  = rqData[s];
        pstrb[s]   = rqStrb[s];
      end
    end
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++)
      if (rqAct[s]) penable[s] = 1'b1;
    rsWaits = 0;
    done = 0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      done = 1;
      for (int s = 0; s < 2; s++)
        if (rqAct[s] && !pready[s]) done = 0;
      if (!done) rsWaits++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout pready never seen within 8 cycles");
    end
    for (int s = 0; s < 2; s++) begin
      rsData[s] = prdata[s];
      rsErr[s]  = pslverr[s];
      rsIrq[s]  = irq[s];
    end
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      psel[s]    = 1'b0;
      penable[s] = 1'b0;
    end
  endtask

  task automatic issue();
    for (int s = 0; s < 2; s++) begin
      if (rqAct[s]) modelEval(s);
      else begin
        ePush[s] = 0; ePop[s] = 0; eFlush[s] = 0; eEn[s] = 0;
      end
    end
    runXfer();
    modelCommit();
    rqAct[0] = 0;
    rqAct[1] = 0;
  endtask

  task automatic acc(input int s, input bit wr, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] st);
    rqAct[s]  = 1;
    rqWr[s]   = wr;
    rqAddr[s] = a;
    rqData[s] = d;
    rqStrb[s] = st;
    issue();
  endtask

  task automatic dualAcc(input bit aWr, input logic [11:0] aAddr,
                         input logic [31:0] aData, input bit bWr,
                         input logic [11:0] bAddr, input logic [31:0] bData);
    rqAct[0] = 1; rqWr[0] = aWr; rqAddr[0] = aAddr;
    rqData[0] = aData; rqStrb[0] = 4'hF;
    rqAct[1] = 1; rqWr[1] = bWr; rqAddr[1] = bAddr;
    rqData[1] = bData; rqStrb[1] = 4'hF;
    issue();
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    qAB.delete();
    qBA.delete();
    mEn[0] = '0;
    mEn[1] = '0;
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (pready[s] !== 1'b0 || prdata[s] !== 32'h0 ||
          pslverr[s] !== 1'b0 || irq[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs side%0d rdy=%b data=%h err=%b irq=%b exp all 0",
                 s, pready[s], prdata[s], pslverr[s], irq[s]);
      end
    end
    acc(0, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[0] !== 32'h0001_0000 || rsErr[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got %h/%b exp 00010000/0", rsData[0], rsErr[0]);
    end
    checks++;
    if (rsWaits !== 1) begin
      errors++;
      $display("FAIL wait_states got %0d exp 1", rsWaits);
    end
    checks++;
    if (irq[0] !== 1'b0 || irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b%b exp 00", irq[0], irq[1]);
    end
  endtask

  task automatic test_doorbell();
    acc(1, 1, AEn, 32'h1, 4'hF);
    acc(0, 1, ATx, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (rsErr[0] !== 1'b0 || rsIrq[1] !== 1'b0 || irq[1] !== 1'b1) begin
      errors++;
      $display("FAIL doorbell_rise err=%b irqAtResp=%b irqAfter=%b exp 0 0 1",
               rsErr[0], rsIrq[1], irq[1]);
    end
    acc(1, 0, ARx, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'hDEAD_BEEF || rsErr[1] !== 1'b0) begin
      errors++;
      $display("FAIL doorbell_pop got %h/%b exp deadbeef/0", rsData[1], rsErr[1]);
    end
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL doorbell_fall irq_b=%b exp 0", irq[1]);
    end
    acc(1, 1, AEn, 32'h0, 4'hF);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      acc(0, 1, ATx, 32'(i), 4'hF);
      checks++;
      if (rsErr[0] !== 1'b0) begin
        errors++;
        $display("FAIL fill_push%0d err=%b exp 0", i, rsErr[0]);
      end
    end
    acc(0, 1, ATx, 32'h99, 4'hF);
    checks++;
    if (rsErr[0] !== 1'b1) begin
      errors++;
      $display("FAIL push_full err=%b exp 1", rsErr[0]);
    end
    acc(1, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'h0000_0008) begin
      errors++;
      $display("FAIL b_status_full got %h exp 00000008", rsData[1]);
    end
    acc(0, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[0] !== 32'h0003_0800) begin
      errors++;
      $display("FAIL a_status_full got %h exp 00030800", rsData[0]);
    end
    for (int i = 0; i < 8; i++) begin
      acc(1, 0, ARx, 0, 4'hF);
      checks++;
      if (rsData[1] !== 32'(i) || rsErr[1] !== 1'b0) begin
        errors++;
        $display("FAIL drain%0d got %h/%b exp %h/0", i, rsData[1], rsErr[1], i);
      end
    end
    acc(1, 0, ARx, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'h0 || rsErr[1] !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty got %h/%b exp 0/1", rsData[1], rsErr[1]);
    end
  endtask

  task automatic test_threshold();
    acc(1, 1, AEn, 32'h0302, 4'hF);
    for (int i = 0; i < 3; i++) begin
      acc(0, 1, ATx, 32'h40 + 32'(i), 4'hF);
      checks++;
      if (irq[1] !== (i == 2)) begin
        errors++;
        $display("FAIL thresh_push%0d irq_b=%b exp %b", i, irq[1], i == 2);
      end
    end
    acc(0, 1, AFl, 32'h1, 4'hF);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_irq irq_b=%b exp 0", irq[1]);
    end
    acc(1, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL flush_status got %h exp 00010000", rsData[1]);
    end
    acc(1, 1, AEn, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) acc(0, 1, ATx, 32'h100 + 32'(i), 4'hF);
    dualAcc(1, ATx, 32'hAAAA, 0, ARx, 0);
    checks++;
    if (rsErr[0] !== 1'b1 || rsData[1] !== 32'h100 || rsErr[1] !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop aErr=%b bData=%h bErr=%b exp 1 100 0",
               rsErr[0], rsData[1], rsErr[1]);
    end
    acc(1, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'h7) begin
      errors++;
      $display("FAIL level_after_full_pp got %h exp 00000007", rsData[1]);
    end
    for (int i = 1; i < 4; i++) begin
      acc(1, 0, ARx, 0, 4'hF);
      checks++;
      if (rsData[1] !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_pop%0d got %h exp %h", i, rsData[1], 32'h100 + 32'(i));
      end
    end
    dualAcc(1, ATx, 32'h200, 0, ARx, 0);
    checks++;
    if (rsErr[0] !== 1'b0 || rsData[1] !== 32'h104 || rsErr[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_push_pop aErr=%b bData=%h bErr=%b exp 0 104 0",
               rsErr[0], rsData[1], rsErr[1]);
    end
    acc(1, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'h4) begin
      errors++;
      $display("FAIL level_kept got %h exp 00000004", rsData[1]);
    end
    dualAcc(1, AFl, 32'h1, 0, ARx, 0);
    checks++;
    if (rsData[1] !== 32'h105 || rsErr[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_pop got %h/%b exp 105/0", rsData[1], rsErr[1]);
    end
    acc(1, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL flush_pop_status got %h exp 00010000", rsData[1]);
    end
  endtask

  task automatic test_errors();
    acc(0, 1, ATx, 32'h77, 4'h3);
    checks++;
    if (rsErr[0] !== 1'b1) begin
      errors++;
      $display("FAIL partial_strobe err=%b exp 1", rsErr[0]);
    end
    acc(0, 1, 12'h040, 32'h55, 4'hF);
    checks++;
    if (rsErr[0] !== 1'b1) begin
      errors++;
      $display("FAIL hi_addr_write err=%b exp 1", rsErr[0]);
    end
    acc(0, 0, 12'h048, 0, 4'hF);
    checks++;
    if (rsErr[0] !== 1'b1 || rsData[0] !== 32'h0) begin
      errors++;
      $display("FAIL hi_addr_read got %h/%b exp 0/1", rsData[0], rsErr[0]);
    end
    acc(1, 0, ASt, 0, 4'hF);
    checks++;
    if (rsData[1] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL no_side_effect got %h exp 00010000", rsData[1]);
    end
    acc(1, 0, 12'h014, 0, 4'hF);
    checks++;
    if (rsErr[1] !== 1'b1) begin
      errors++;
      $display("FAIL bad_offset err=%b exp 1", rsErr[1]);
    end
    acc(1, 1, ARx, 32'h1, 4'hF);
    checks++;
    if (rsErr[1] !== 1'b1) begin
      errors++;
      $display("FAIL rx_write err=%b exp 1", rsErr[1]);
    end
    acc(0, 1, ASt, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (rsErr[0] !== 1'b0) begin
      errors++;
      $display("FAIL status_write err=%b exp 0", rsErr[0]);
    end
    acc(0, 1, AEn, 32'hFFFF_FFFF, 4'hF);
    acc(0, 0, AEn, 0, 4'hF);
    checks++;
    if (rsData[0] !== 32'h0000_0F03) begin
      errors++;
      $display("FAIL irqen_mask got %h exp 00000f03", rsData[0]);
    end
    acc(0, 1, AEn, 32'h2, 4'hF);
    checks++;
    if (irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL thresh_zero irq_a=%b exp 1", irq[0]);
    end
    acc(0, 1, AEn, 32'h0, 4'hF);
    checks++;
    if (irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL irq_disable irq_a=%b exp 0", irq[0]);
    end
  endtask

  task automatic test_reset_mid();
    acc(0, 1, ATx, 32'h11, 4'hF);
    acc(1, 1, ATx, 32'h22, 4'hF);
    acc(0, 1, AEn, 32'h1, 4'hF);
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = ASt;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pready[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_resp pready=%b exp 1", pready[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (pready[0] !== 1'b0 || prdata[0] !== 32'h0 || pslverr[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid rdy=%b data=%h err=%b exp 0 0 0",
               pready[0], prdata[0], pslverr[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    qAB.delete(); qBA.delete(); mEn[0] = '0; mEn[1] = '0;
    @(negedge clk);
    checks++;
    if (pready[0] !== 1'b0 || irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle rdy=%b irq=%b exp 0 0", pready[0], irq[0]);
    end
    for (int s = 0; s < 2; s++) begin
      acc(s, 0, ASt, 0, 4'hF);
      checks++;
      if (rsData[s] !== 32'h0001_0000) begin
        errors++;
        $display("FAIL reset_fifo side%0d got %h exp 00010000", s, rsData[s]);
      end
    end
    acc(0, 0, AEn, 0, 4'hF);
    checks++;
    if (rsData[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_irqen got %h exp 0", rsData[0]);
    end
  endtask

  task automatic genReq(input int s);
    int r;
    r = int'($urandom_range(0, 99));
    rqAct[s]  = 1;
    rqWr[s]   = 0;
    rqAddr[s] = ASt;
    rqData[s] = $urandom;
    rqStrb[s] = 4'hF;
    if (r < 35) begin
      rqWr[s] = 1; rqAddr[s] = ATx;
      if ($urandom_range(0, 7) == 0) rqStrb[s] = 4'($urandom);
    end else if (r < 62) begin
      rqAddr[s] = ARx;
    end else if (r < 72) begin
      rqAddr[s] = ASt;
    end else if (r < 80) begin
      rqWr[s] = 1; rqAddr[s] = AEn;
      rqData[s][11:8] = 4'($urandom_range(0, 9));
    end else if (r < 84) begin
      rqAddr[s] = AEn;
    end else if (r < 87) begin
      rqWr[s] = 1; rqAddr[s] = AFl;
    end else if (r < 92) begin
      rqWr[s] = 1'($urandom);
      rqAddr[s] = 12'(4 * $urandom_range(5, 15));
    end else if (r < 96) begin
      rqWr[s] = 1'($urandom);
      rqAddr[s] = 12'($urandom_range(1, 63) << 6) | 12'(4 * $urandom_range(0, 4));
    end else begin
      rqWr[s] = 1'($urandom);
      rqAddr[s] = 12'(4 * $urandom_range(0, 4));
    end
  endtask

  task automatic test_random();
    bit act [2];
    doReset();
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        genReq(0);
        genReq(1);
      end else begin
        genReq(int'($urandom_range(0, 1)));
      end
      act[0] = rqAct[0];
      act[1] = rqAct[1];
      issue();
      for (int s = 0; s < 2; s++) begin
        if (act[s]) begin
          checks++;
          if (rsData[s] !== mExpData[s] || rsErr[s] !== mExpErr[s]) begin
            errors++;
            $display("FAIL rand_resp it%0d side%0d got %h/%b exp %h/%b",
                     it, s, rsData[s], rsErr[s], mExpData[s], mExpErr[s]);
          end
        end
        checks++;
        if (irq[s] !== modelIrq(s)) begin
          errors++;
          $display("FAIL rand_irq it%0d side%0d got %b exp %b",
                   it, s, irq[s], modelIrq(s));
        end
      end
      checks++;
      if (rsWaits !== 1) begin
        errors++;
        $display("FAIL rand_waits it%0d got %0d exp 1", it, rsWaits);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      paddr[s] = '0; psel[s] = 1'b0; penable[s] = 1'b0;
      pwrite[s] = 1'b0; pwdata[s] = '0; pstrb[s] = 4'hF;
      rqAct[s] = 0; mEn[s] = '0;
    end
    test_reset();
    test_doorbell();
    test_fill_drain();
    test_threshold();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
